// File: rtl/vga_timing_gen_pkg.sv
// Default VGA timing constants (1024x768 @ 60 Hz, 65 MHz pixel clock) and the
// small helpers shared by the timing generator.
package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int HOR_FP     = 24;
  localparam int HOR_SYNC   = 136;
  localparam int HOR_BP     = 160;
  localparam int HOR_TOTAL  = HOR_PIXELS + HOR_FP + HOR_SYNC + HOR_BP;

  localparam int VER_PIXELS = 768;
  localparam int VER_FP     = 3;
  localparam int VER_SYNC   = 6;
  localparam int VER_BP     = 29;
  localparam int VER_TOTAL  = VER_PIXELS + VER_FP + VER_SYNC + VER_BP;

  localparam int CNT_W = 11;
  localparam int RGB_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  // Half-open window test lo <= v < hi, used for the sync pulses.
  function automatic logic in_win(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Head of the draw_* pipeline: free-running h/v counters with registered
// sync/blank flags decoded from the next count so flags and counts line up.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = HOR_PIXELS,
  parameter int H_FP     = HOR_FP,
  parameter int H_SYNC   = HOR_SYNC,
  parameter int H_BP     = HOR_BP,
  parameter int V_ACTIVE = VER_PIXELS,
  parameter int V_FP     = VER_FP,
  parameter int V_SYNC   = VER_SYNC,
  parameter int V_BP     = VER_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam cnt_t H_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t H_HS_LO = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_HS_HI = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t V_VS_LO = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_VS_HI = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t h_nxt, v_nxt;
  logic h_wrap, v_wrap;
  // The 0,0 position shown during reset never got a frame_start, so the
  // first enabled cycle after reset still owes the pulse for that frame.
  logic first_pend;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_nxt  = h_wrap ? '0 : hcount + cnt_t'(1);
    v_nxt  = vcount;
    if (h_wrap) v_nxt = v_wrap ? '0 : vcount + cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    rgb <= '0;
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      first_pend  <= 1'b1;
    end else if (en) begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= (h_nxt >= H_ACT);
      vblnk       <= (v_nxt >= V_ACT);
      hsync       <= in_win(h_nxt, H_HS_LO, H_HS_HI);
      vsync       <= in_win(v_nxt, V_VS_LO, V_VS_HI);
      frame_start <= first_pend || (h_wrap && v_wrap);
      first_pend  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001 Parameter H_ACTIVE, default 1024: visible pixels per line.
- REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 24 / 136 / 160: horizontal front porch, sync width and back porch, in pixels.
- REQ-003 Parameter V_ACTIVE, default 768: visible lines per frame.
- REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 3 / 6 / 29: vertical front porch, sync width and back porch, in lines.
- REQ-005 Port clk, input, 1: pixel clock (65 MHz).
- REQ-006 Port rst, input, 1: synchronous, active-high reset.
- REQ-007 Port en, input, 1: pixel enable; counters advance only when en=1.
- REQ-008 Port vga_out.hcount, output, 11: horizontal position, 0..H_TOTAL-1.
- REQ-009 Port vga_out.vcount, output, 11: vertical position, 0..V_TOTAL-1.
- REQ-010 Port vga_out.hsync / vga_out.vsync, output, 1 each: active-high sync pulses.
- REQ-011 Port vga_out.hblnk / vga_out.vblnk, output, 1 each: active-high blanking.
- REQ-012 Port vga_out.rgb, output, 12: constant 12'h000; downstream draw stages overwrite it.
- REQ-013 Port frame_start, output, 1: one-cycle pulse when hcount=0 and vcount=0 is first presented.

Function
- REQ-014 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1344) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (806) SHALL be computed at elaboration.
- REQ-015 On a cycle with en=1, hcount SHALL increment by 1 and wrap from H_TOTAL-1 to 0.
- REQ-016 vcount SHALL increment only on the en=1 cycle in which hcount wraps, and SHALL itself wrap from V_TOTAL-1 to 0.
- REQ-017 On a cycle with en=0, all outputs SHALL hold their values and frame_start SHALL be 0.
- REQ-018 hblnk SHALL be 1 iff hcount >= H_ACTIVE.
- REQ-019 hsync SHALL be 1 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (defaults: 1048..1183).
- REQ-020 vblnk SHALL be 1 iff vcount >= V_ACTIVE.
- REQ-021 vsync SHALL be 1 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (defaults: 771..776).
- REQ-022 Every output SHALL be registered, and the sync/blank flags SHALL be consistent with hcount/vcount in the same cycle: next-state decode, no extra latency between count and flag.
- REQ-023 frame_start SHALL assert in the cycle in which the outputs change to hcount=0, vcount=0, including the first en=1 cycle after reset.
- REQ-024 Arithmetic SHALL be unsigned and 11 bits wide, with no intermediate overflow for the default parameters.

Reset
- REQ-025 While rst=1, the outputs SHALL be hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, rgb=0 and frame_start=0, regardless of en.
- REQ-026 rst asserted mid-frame SHALL abort the frame immediately, with no completion of the current line.
- REQ-027 On the first en=1 cycle after rst deasserts, hcount SHALL be 1 and vcount 0.

Structure
- REQ-028 The default timing constants (HOR_PIXELS, VER_PIXELS, the porch and sync widths, HOR_TOTAL, VER_TOTAL) SHALL live in vga_pkg, and the parameters SHALL default from them.
- REQ-029 The module SHALL drive vga_if.out as the head of the draw_* pipeline.
- REQ-030 No sub-module is required; the horizontal and vertical counters SHALL live in one module.

Verification
- REQ-031 Reset, then en=1 for 1344 cycles: hcount runs 0..1343 and returns to 0, and vcount steps 0->1 exactly at the wrap.
- REQ-032 Line check: hblnk rises at hcount=1024; hsync is high for hcount 1048..1183 (136 cycles) and low elsewhere.
- REQ-033 Full frame, 1344*806 = 1,083,264 en cycles: vblnk is high for vcount 768..805, vsync for 771..776, and frame_start pulses exactly once per frame.
- REQ-034 en toggled 1/0 every cycle: counts advance every second cycle, and the frame period is 2,166,528 clocks.
- REQ-035 rst asserted at hcount=500, vcount=300 for 1 cycle: all outputs are 0 the next cycle, and counting restarts from 0.
- REQ-036 A scoreboard compares every cycle's sync/blank flags against the hcount/vcount equations in REQ-018..021, with zero mismatches.
